ahb_req_master: RTL and testbench

Synthesizable AHB-Lite initiator that turns a simple valid/ready request stream into single AHB transfers (HBURST=SINGLE, HTRANS IDLE/NONSEQ only). It drives the bus towards slaves such as the simulation debug/print port (putc 0x40000000, hex 0x40000008, file ops 0x4000000C..0x40001400). Address and data phases are pipelined, so one transfer can be in the data phase while the next is in the address phase. Read data and errors return on a one-cycle response pulse.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_req_master.sv | 155 +++++++++++++++
 tb/tb_ahb_req_master.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the error-FSM state type for the request master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic {
    RUN  = 1'b0,
    ERR2 = 1'b1
  } state_t;

endpackage

// File: rtl/ahb_req_master.sv
// AHB-Lite initiator: converts a valid/ready request stream into pipelined
// SINGLE transfers and returns one response pulse per accepted request.
//
// Handshake: a request transfers at a rising HCLK edge where req_valid and
// req_ready are both high; the caller must hold req_* stable until then.
// rsp_valid is a single-cycle pulse with no back-pressure.
module ahb_req_master
  import ahb_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_DEF = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_wdata_q;   // write data riding along with the address phase
  logic              d_valid_q;   // a transfer occupies the data phase
  logic              d_write_q;
  logic              abort_pend_q; // an address-phase transfer was cancelled by an error
  logic              abort_q;      // cycle in which the abort response is emitted
  logic              accept;
  logic              err_first;
  logic [2:0]        size_eff;
  logic [ADDR_W-1:0] addr_aligned;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEF;
  assign dbg_state = state_q;

  // The abort-pulse cycle blocks acceptance so the abort response stays in order.
  assign req_ready = HREADY && (state_q == RUN) && !abort_q;
  assign accept    = req_valid && req_ready;
  assign err_first = (state_q == RUN) && d_valid_q && (HRESP == HRESP_ERROR) && !HREADY;

  // Clamp illegal sizes to a word and clear address bits below the transfer size.
  always_comb begin
    size_eff     = (req_size > HSIZE_WORD) ? HSIZE_WORD : req_size;
    addr_aligned = req_addr;
    if (size_eff == HSIZE_HALF) addr_aligned[0] = 1'b0;
    if (size_eff == HSIZE_WORD) addr_aligned[1:0] = 2'b00;
  end

  // Error FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Error FSM next state: enter ERR2 on the first ERROR cycle, leave when it completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (err_first) state_d = ERR2;
      ERR2:    if (HREADY)    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Address phase: load on accept, cancel a pending NONSEQ on the first error cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_BYTE;
      a_wdata_q <= '0;
    end else if (err_first) begin
      HTRANS <= HTRANS_IDLE;
    end else if (HREADY) begin
      if (accept) begin
        HTRANS    <= HTRANS_NONSEQ;
        HADDR     <= addr_aligned;
        HWRITE    <= req_write;
        HSIZE     <= size_eff;
        a_wdata_q <= req_wdata;
      end else begin
        HTRANS <= HTRANS_IDLE;
      end
    end
  end

  // Data phase: the address-phase transfer advances whenever HREADY is high.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      HWDATA    <= '0;
    end else if (HREADY) begin
      d_valid_q <= (HTRANS == HTRANS_NONSEQ);
      d_write_q <= HWRITE;
      if ((HTRANS == HTRANS_NONSEQ) && HWRITE) HWDATA <= a_wdata_q;
    end
  end

  // Abort bookkeeping: remember a cancelled transfer and pulse after the error completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      abort_pend_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (err_first && (HTRANS == HTRANS_NONSEQ)) begin
        abort_pend_q <= 1'b1;
      end else if ((state_q == ERR2) && HREADY) begin
        abort_q      <= abort_pend_q;
        abort_pend_q <= 1'b0;
      end
    end
  end

  // Response pulse: data-phase completion or the deferred abort response.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (abort_q) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end else if (HREADY && d_valid_q) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= d_write_q ? '0 : HRDATA;
        rsp_err   <= (HRESP == HRESP_ERROR);
      end
    end
  end

endmodule

// File: tb/tb_ahb_req_master.sv
// Directed, table-driven bench for ahb_req_master. Each table row holds the
// inputs applied for one HCLK cycle and the outputs expected in that cycle.
module tb_ahb_req_master;
  import ahb_pkg::*;

  localparam logic [31:0] A  = 32'h4000_0000;
  localparam logic [31:0] B3 = 32'h4000_1003;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        v, w;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] wd;
    logic        hr, hp;
    logic [31:0] rd;
    logic [1:0]  t;
    logic [31:0] ha;
    logic        hw;
    logic [2:0]  hs;
    logic [31:0] hwd;
    logic        rv;
    logic [31:0] rr;
    logic        re, rdy, st;
  } vec_t;

  vec_t tbl[$];

  ahb_req_master #(.ADDR_W(32), .DATA_W(32), .HPROT_DEF(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL row %0d %s actual=%h required=%h", row, name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic w, input logic [31:0] a, input logic [2:0] s,
    input logic [31:0] wd, input logic hr, input logic hp, input logic [31:0] rd,
    input logic [1:0] t, input logic [31:0] ha, input logic hw, input logic [2:0] hs,
    input logic [31:0] hwd, input logic rv, input logic [31:0] rr, input logic re,
    input logic rdy, input logic st);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.s = s; r.wd = wd; r.hr = hr; r.hp = hp; r.rd = rd;
    r.t = t; r.ha = ha; r.hw = hw; r.hs = hs; r.hwd = hwd; r.rv = rv; r.rr = rr;
    r.re = re; r.rdy = rdy; r.st = st;
    return r;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] wd, input logic hr, input logic hp, input logic [31:0] rd);
    req_valid = v; req_write = w; req_addr = a; req_size = s; req_wdata = wd;
    HREADY = hr; HRESP = hp; HRDATA = rd;
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same point of the next cycle.
  task automatic run_table(input int base);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, tbl[i].hr, tbl[i].hp, tbl[i].rd);
      #1;
      chk("HTRANS",    base + i, 32'(HTRANS),    32'(tbl[i].t));
      chk("HADDR",     base + i, HADDR,          tbl[i].ha);
      chk("HWRITE",    base + i, 32'(HWRITE),    32'(tbl[i].hw));
      chk("HSIZE",     base + i, 32'(HSIZE),     32'(tbl[i].hs));
      chk("HWDATA",    base + i, HWDATA,         tbl[i].hwd);
      chk("rsp_valid", base + i, 32'(rsp_valid), 32'(tbl[i].rv));
      chk("rsp_rdata", base + i, rsp_rdata,      tbl[i].rr);
      chk("rsp_err",   base + i, 32'(rsp_err),   32'(tbl[i].re));
      chk("req_ready", base + i, 32'(req_ready), 32'(tbl[i].rdy));
      chk("state",     base + i, 32'(dbg_state), 32'(tbl[i].st));
      @(posedge HCLK);
      #1;
    end
    tbl.delete();
  endtask

  task automatic chk_reset_outputs(input int row);
    chk("rst HTRANS",    row, 32'(HTRANS),    32'(HTRANS_IDLE));
    chk("rst HADDR",     row, HADDR,          32'h0);
    chk("rst HWRITE",    row, 32'(HWRITE),    32'h0);
    chk("rst HSIZE",     row, 32'(HSIZE),     32'h0);
    chk("rst HWDATA",    row, HWDATA,         32'h0);
    chk("rst rsp_valid", row, 32'(rsp_valid), 32'h0);
    chk("rst rsp_rdata", row, rsp_rdata,      32'h0);
    chk("rst rsp_err",   row, 32'(rsp_err),   32'h0);
    chk("rst state",     row, 32'(dbg_state), 32'(RUN));
  endtask

  initial begin
    HRESET = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge HCLK);
    #1;
    chk_reset_outputs(-1);
    chk("HBURST", -1, 32'(HBURST), 32'h0);
    chk("HPROT",  -1, 32'(HPROT),  32'h3);
    HRESET = 1'b0;

    //              v  w  addr        s  wdata  hr hp rdata         | t  haddr          hw hs hwdata  rv rdata        re rdy st
    // write putc, zero wait states
    tbl.push_back(mk(1, 1, A,          0, 32'h41, 1, 0, 0,             0, 0,              0, 0, 0,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             2, A,              1, 0, 0,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A,              1, 0, 32'h41, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A,              1, 0, 32'h41, 1, 0,            0, 1, 0));
    // three back-to-back writes
    tbl.push_back(mk(1, 1, A+32'h0C,   2, 1,      1, 0, 0,             0, A,              1, 0, 32'h41, 0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 1, A+32'h10,   2, 2,      1, 0, 0,             2, A+32'h0C,       1, 2, 32'h41, 0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 1, A+32'h14,   2, 3,      1, 0, 0,             2, A+32'h10,       1, 2, 1,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             2, A+32'h14,       1, 2, 2,      1, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h14,       1, 2, 3,      1, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h14,       1, 2, 3,      1, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h14,       1, 2, 3,      0, 0,            0, 1, 0));
    // read with two wait states, next write held in the address phase
    tbl.push_back(mk(1, 0, A+32'h20,   2, 0,      1, 0, 0,             0, A+32'h14,       1, 2, 3,      0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 1, A+32'h24,   2, 5,      1, 0, 0,             2, A+32'h20,       0, 2, 3,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      0, 0, 0,             2, A+32'h24,       1, 2, 3,      0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      0, 0, 0,             2, A+32'h24,       1, 2, 3,      0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 32'hDEADBEEF,  2, A+32'h24,       1, 2, 3,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h24,       1, 2, 5,      1, 32'hDEADBEEF, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h24,       1, 2, 5,      1, 0,            0, 1, 0));
    // errored read with a write pending in the address phase
    tbl.push_back(mk(1, 0, A+32'h30,   2, 0,      1, 0, 0,             0, A+32'h24,       1, 2, 5,      0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 1, A+32'h04,   2, 7,      1, 0, 0,             2, A+32'h30,       0, 2, 5,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      0, 1, 0,             2, A+32'h04,       1, 2, 5,      0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 1, 0,             0, A+32'h04,       1, 2, 5,      0, 0,            0, 0, 1));
    tbl.push_back(mk(1, 1, A+32'h08,   2, 9,      1, 0, 0,             0, A+32'h04,       1, 2, 5,      1, 0,            1, 0, 0));
    tbl.push_back(mk(1, 1, A+32'h08,   2, 9,      1, 0, 0,             0, A+32'h04,       1, 2, 5,      1, 0,            1, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             2, A+32'h08,       1, 2, 5,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h08,       1, 2, 9,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A+32'h08,       1, 2, 9,      1, 0,            0, 1, 0));
    // address alignment and illegal size clamping, pipelined reads
    tbl.push_back(mk(1, 0, B3,         2, 0,      1, 0, 0,             0, A+32'h08,       1, 2, 9,      0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 0, B3,         1, 0,      1, 0, 0,             2, 32'h4000_1000,  0, 2, 9,      0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 0, B3,         3, 0,      1, 0, 32'h11,        2, 32'h4000_1002,  0, 1, 9,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 32'h22,        2, 32'h4000_1000,  0, 2, 9,      1, 32'h11,       0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 32'h33,        0, 32'h4000_1000,  0, 2, 9,      1, 32'h22,       0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, 32'h4000_1000,  0, 2, 9,      1, 32'h33,       0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, 32'h4000_1000,  0, 2, 9,      0, 0,            0, 1, 0));
    run_table(0);

    // Reset in the middle of a waited data phase.
    drive(1, 0, A+32'h40, 2, 0, 1, 0, 0);
    @(posedge HCLK); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h55);
    @(posedge HCLK); #1;
    chk("pre-reset HADDR", 100, HADDR, A+32'h40);
    HRESET = 1'b1;
    #1;
    chk_reset_outputs(101);
    chk("rst req_ready", 101, 32'(req_ready), 32'h0);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, 0,              0, 0, 0,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, 0,              0, 0, 0,      0, 0,            0, 1, 0));
    tbl.push_back(mk(1, 1, A,          0, 32'h42, 1, 0, 0,             0, 0,              0, 0, 0,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             2, A,              1, 0, 0,      0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A,              1, 0, 32'h42, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,      1, 0, 0,             0, A,              1, 0, 32'h42, 1, 0,            0, 1, 0));
    run_table(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
